// File: rtl/mips_funct_pkg.sv
// mips_funct_pkg: funct codes shared by the ALU and the mul/div unit, plus the mul/div FSM states
package mips_funct_pkg;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO/MFHI/MFLO access.
// MULDIV_DIVZERO_FAST_EN: zero-divisor divides skip CALC and raise o_div_zero with o_done.
module muldiv_unit
    import mips_funct_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [5:0]       i_func,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_result
`ifdef MULDIV_DIVZERO_FAST_EN
    ,
    output logic             o_div_zero
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t          state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0]   m, mag1, mag2, res_hi, res_lo;
    logic [WIDTH:0]     sum, sh, diff;
    logic               is_div, neg_q, neg_r, is_md, is_sgn, is_dv, zero2, fast, accept;

    always_comb begin
        is_md  = i_func inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
        is_dv  = i_func == F_DIV || i_func == F_DIVU;
        is_sgn = i_func == F_MULT || i_func == F_DIV;
        zero2  = i_op2 == '0;
        mag1   = is_sgn && i_op1[WIDTH-1] ? -i_op1 : i_op1;
        mag2   = is_sgn && i_op2[WIDTH-1] ? -i_op2 : i_op2;
        accept = state == IDLE && i_start && is_md;
        // multiply: add multiplicand into the upper half (carry kept in sum[WIDTH]) then shift right
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        // divide: upper half is the partial remainder, lower half shifts dividend out and quotient in
        sh     = acc[2*WIDTH-1:WIDTH-1];
        diff   = sh - {1'b0, m};
        acc_nx = is_div ? {diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                        : {sum, acc[WIDTH-1:1]};
        res_hi = is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                        : (neg_q ? -acc[2*WIDTH-1:WIDTH] - {{(WIDTH-1){1'b0}}, acc[WIDTH-1:0] != '0}
                                 : acc[2*WIDTH-1:WIDTH]);
        res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

`ifdef MULDIV_DIVZERO_FAST_EN
    assign fast = is_dv && zero2;
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? (fast ? FIX : CALC) : IDLE;
            CALC:    state_nx = cnt == CW'(WIDTH - 1) ? FIX : CALC;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hi   <= '0;
            o_lo   <= '0;
            o_done <= 1'b0;
            cnt    <= '0;
        end else begin
            o_done <= state == FIX;
            if (accept) begin
                is_div <= is_dv;
                // a zero divisor leaves the all-ones quotient unsigned
                neg_q  <= is_sgn && (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]) && !zero2;
                neg_r  <= is_sgn && i_op1[WIDTH-1];
                m      <= is_dv ? mag2 : mag1;
                acc    <= fast ? {mag1, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, is_dv ? mag1 : mag2};
                cnt    <= '0;
            end else if (state == IDLE && i_start && i_func == F_MTHI) begin
                o_hi <= i_op1;
            end else if (state == IDLE && i_start && i_func == F_MTLO) begin
                o_lo <= i_op1;
            end else if (state == CALC) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end else if (state == FIX) begin
                o_hi <= res_hi;
                o_lo <= res_lo;
            end
        end
    end

`ifdef MULDIV_DIVZERO_FAST_EN
    logic dz_lat;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dz_lat     <= 1'b0;
            o_div_zero <= 1'b0;
        end else begin
            if (accept) dz_lat <= fast;
            o_div_zero <= state == FIX && dz_lat;
        end
    end
`endif

    assign o_busy   = state != IDLE;
    assign o_result = i_func == F_MFHI ? o_hi : i_func == F_MFLO ? o_lo : '0;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the execute stage and takes the same operand pair (op1 = rs, op2 = rt) and the same 6-bit funct code. It serves MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. The controller stalls the core while o_busy is high, and the writeback mux selects o_result for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width. Iteration count equals WIDTH.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous, active-high reset
i_start  input  1  request strobe; sampled only when idle
i_func  input  6  funct code (MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011)
i_op1  input  WIDTH  rs: multiplicand / dividend / MTHI-MTLO source
i_op2  input  WIDTH  rt: multiplier / divisor
o_busy  output  1  high whenever state != IDLE
o_done  output  1  one-cycle pulse; HI/LO hold the new result in the same cycle
o_hi  output  WIDTH  HI register
o_lo  output  WIDTH  LO register
o_result  output  WIDTH  combinational: HI for MFHI, LO for MFLO, else 0

Behaviour:
- Reset (i_rst=1 at edge): state=IDLE, HI=0, LO=0, o_done=0, counter=0. Reset aborts any operation in flight; no partial result reaches HI/LO.
- States are IDLE, CALC and FIX.
- IDLE, i_start=1, i_func MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes: absolute values for signed ops, raw for unsigned.
  - Latch result sign flags.
  - counter=0, go to CALC.
- IDLE, i_start=1, i_func MTHI/MTLO: write i_op1 to HI/LO at that edge. Stay IDLE, no o_done.
- IDLE, i_start=1, any other func: no effect.
- CALC: one iteration per edge; counter increments. After WIDTH edges go to FIX.
  - Multiply: radix-2 shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX: one edge. Apply signs, write HI/LO, go to IDLE. o_done=1 in the following cycle only.
  - Multiply: product negated if the operand signs differ. HI=upper half, LO=lower half.
  - Divide: quotient negated if the operand signs differ. Remainder takes the dividend sign. HI=remainder, LO=quotient.
- Latency: accept edge, then WIDTH CALC edges, then 1 FIX edge. o_busy is high for WIDTH+1 cycles. o_done coincides with the first IDLE cycle, so a new start may be accepted in the o_done cycle.
- i_start while busy is ignored, including MTHI/MTLO. The controller must hold the instruction until o_busy falls.
- Operands are captured at accept. Changes on i_op1/i_op2 during CALC have no effect.
- Divide by zero (op2=0), signed or unsigned: LO=all ones, HI=op1 unchanged. There is no exception.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MULTU of maximal operands must not lose the carry. The product register is 2*WIDTH wide, plus one carry bit during accumulation.
- o_result tracks HI/LO combinationally and is valid in any state. During busy it reflects the old HI/LO.

Optional Feature:
Macro MULDIV_DIVZERO_FAST_EN.
- Defined:
  - DIV/DIVU with op2=0 skips CALC and goes IDLE, FIX, IDLE. o_done appears 2 cycles after accept.
  - Adds output port o_div_zero (1 bit). It is high with o_done for a zero-divisor divide, else 0, and reset to 0.
- Undefined: zero divisors take the full WIDTH+2 path with identical HI/LO values. The o_div_zero port does not exist.

Decomposition:
- Shared package mips_funct_pkg: all funct localparams used by both the ALU and this block, and the state encoding (IDLE/CALC/FIX).
- No sub-module is needed. A single FSM plus datapath in one module is natural. The counter width is $clog2(WIDTH)+1.

Test Plan:
1. Reset, then MULT op1=0xFFFFFFFD (-3), op2=5 -> after 33 busy cycles o_done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. DIV -7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100. With MULDIV_DIVZERO_FAST_EN: o_done 2 cycles after accept and o_div_zero=1.
5. MTHI 0x12345678, then immediately MULT 2x3. Issue MTLO 0xAAAA during busy -> MTLO ignored. Final HI=0, LO=6. o_result with MFLO=6.
6. Start DIVU, assert i_rst at CALC cycle 10 -> next cycle o_busy=0, HI=LO=0, o_done never pulses. A new MULT 4x4 then gives LO=16.
